ram_bist: RTL and testbench
===========================

# ram_bist

Built-in self-test controller that drives the single-port synchronous RAM (`we`/`addr`/`data_in`/`data_out`, 7-bit address, 8-bit data) as its only initiator. On `start` it writes an address-salted pattern to every word, reads every word back and compares the result. It reports pass/fail, the first failing address and data, and a saturating error count. It sits between the system control logic and the RAM instance and has exclusive ownership of the RAM port while `busy`.

## Interface
- `ADDR_W`, 7, RAM address width; depth = 2**ADDR_W.
- `DATA_W`, 8, RAM data width.
- `PATTERN`, 8'hAA, base test pattern, DATA_W bits.

- `clk`  in  1  rising-edge clock, shared with the RAM.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a test run; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  1 when the last run had zero mismatches; held until the next accepted `start`.
- `err_count`  out  8  number of mismatches, saturating at 255.
- `fail_addr`  out  ADDR_W  address of the first mismatch.
- `fail_data`  out  DATA_W  data read at the first mismatch.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_din`  out  DATA_W  RAM write data.
- `mem_dout`  in  DATA_W  RAM read data, registered inside the RAM. It is valid one cycle after `mem_addr` is presented with `mem_we`=0.

## Operation
- **States:** IDLE, WRITE, READ, DRAIN, DONE.
- **Expected data:** exp(a) = P ^ zero-extend(a), where P = PATTERN on pass 1.
- **IDLE:**
  - If `start`=1, clear `err_count`, `fail_addr`, `fail_data` and the first-fail flag.
  - Then set the address counter to 0 and go to WRITE.
- **WRITE:**
  - Drive `mem_we`=1, `mem_addr`=a, `mem_din`=exp(a).
  - a increments each cycle.
  - When a = DEPTH-1, wrap a to 0 and go to READ.
- **READ:**
  - Drive `mem_we`=0, `mem_addr`=a; a increments each cycle.
  - Each cycle, compare `mem_dout` against exp(a_prev), where a_prev is the address issued in the previous cycle. No compare is made in the first READ cycle.
  - After a = DEPTH-1 is issued, go to DRAIN.
- **DRAIN:** compare the read of address DEPTH-1. Then go to DONE, or to WRITE for the second pass (see Configuration).
- **DONE:** `done`=1 and `pass` = (err_count==0). Go to IDLE.
- **On mismatch:**
  - `err_count` += 1, saturating at 255.
  - If this is the first mismatch of the run, latch `fail_addr`=a_prev and `fail_data`=`mem_dout`.
- **`start` handling:** `start` while `busy` is ignored. A `start` held high through DONE starts a new run on the next IDLE cycle.
- **Idle outputs:** `mem_we`, `mem_addr` and `mem_din` are 0 whenever the block is not in WRITE or READ.

## Timing
- **Reset values:** state=IDLE; `busy`, `done`, `pass`, `err_count`, `fail_addr`, `fail_data`, `mem_we`, `mem_addr`, `mem_din` all 0.
- **Reset mid-operation:** `rst_n` low forces `mem_we`=0 immediately (asynchronously). The RAM contents are left undefined.
- **Run timeline**, with `start` sampled at edge k and DEPTH=128:
  - WRITE in cycles k+1..k+128.
  - READ in cycles k+129..k+256.
  - DRAIN at k+257.
  - DONE (`done`=1) at k+258.
- **`busy`:** high in cycles k+1..k+258.
- **Output registration:** all outputs are registered. The compare path is one cycle deep, from `mem_dout` to the error registers.

## Configuration
- **`RAM_BIST_INV_PASS_EN` defined:**
  - After the DRAIN of pass 1, go directly to WRITE (a=0) with P = ~PATTERN and repeat WRITE/READ/DRAIN.
  - DONE follows the second DRAIN, at k+515 for DEPTH=128.
  - `err_count` and the first-fail capture accumulate across both passes.
- **Undefined:** single pass only, DONE at k+258.

## Test plan
- **Fault-free run:** fault-free RAM model, `start` pulse at edge k -> `mem_we`=1 for 128 cycles, `done` at k+258 (k+515 with the macro), `pass`=1, `err_count`=0.
- **Single-bit read fault:** RAM model flips bit0 on reads of address 10 -> `pass`=0, `err_count`=1 (2 with the macro), `fail_addr`=10, `fail_data`=8'hA1 (expected 8'hA0).
- **Multiple faults:** faults at addresses 5 and 9 -> `fail_addr`=5 (first only), `err_count`=2 (4 with the macro).
- **Inverted pass only:** bit7 stuck-at-1 at address 20. Pass 1 expects 8'hBE; pass 2 expects 8'h41 and reads 8'hC1.
  - Without the macro -> `pass`=1.
  - With the macro -> `pass`=0, `fail_addr`=20, `fail_data`=8'hC1.
- **`start` while busy:** `start` re-asserted at k+50 -> ignored; single `done` at the nominal cycle and no restart of WRITE.
- **Reset mid-write:** `rst_n` low at k+40 (mid-WRITE) -> `mem_we` drops before the next edge, all outputs 0. A new `start` after release runs a full test to `pass`=1.

Source files
------------

// File: rtl/ram_bist.sv
// ram_bist: built-in self-test controller for a single-port synchronous RAM.
// Writes an address-salted pattern to every word, reads it back and compares.
// Reports pass/fail, the first failing address/data and a saturating error count.
// Optional feature: define RAM_BIST_INV_PASS_EN to add a second pass using the
// inverted base pattern; errors and first-fail capture accumulate across passes.
module ram_bist #(
    parameter int                ADDR_W  = 7,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'hAA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] prev_addr;
    logic              cmp_valid;
    logic              first_seen;
    logic              mismatch;
    logic [7:0]        err_next;

`ifdef RAM_BIST_INV_PASS_EN
    logic              inv_pass;
`else
    logic              inv_pass;
    assign inv_pass = 1'b0;
`endif

    // Pattern for address a: base pattern (inverted on the second pass) XOR the zero-extended address.
    function automatic logic [DATA_W-1:0] expected_data(input logic inv, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] base;
        base = inv ? ~PATTERN : PATTERN;
        return base ^ DATA_W'(a);
    endfunction

    // Compare the read data returned this cycle against the address issued last cycle.
    always_comb begin
        mismatch = cmp_valid && (mem_dout != expected_data(inv_pass, prev_addr));
        err_next = err_count;
        if (mismatch && (err_count != 8'hFF)) begin
            err_next = err_count + 8'd1;
        end
    end

    // Main sequencer: RAM port outputs are registered from the next-state decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_cnt   <= '0;
            prev_addr  <= '0;
            cmp_valid  <= 1'b0;
            first_seen <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
`ifdef RAM_BIST_INV_PASS_EN
            inv_pass   <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            cmp_valid <= (state == S_READ);
            prev_addr <= addr_cnt;
            err_count <= err_next;
            if (mismatch && !first_seen) begin
                first_seen <= 1'b1;
                fail_addr  <= prev_addr;
                fail_data  <= mem_dout;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_count  <= '0;
                        fail_addr  <= '0;
                        fail_data  <= '0;
                        first_seen <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        addr_cnt   <= '0;
                        mem_we     <= 1'b1;
                        mem_addr   <= '0;
                        mem_din    <= expected_data(1'b0, '0);
`ifdef RAM_BIST_INV_PASS_EN
                        inv_pass   <= 1'b0;
`endif
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (addr_cnt == {ADDR_W{1'b1}}) begin
                        addr_cnt <= '0;
                        mem_addr <= '0;
                        state    <= S_READ;
                    end else begin
                        addr_cnt <= addr_cnt + 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= addr_cnt + 1'b1;
                        mem_din  <= expected_data(inv_pass, addr_cnt + 1'b1);
                    end
                end
                S_READ: begin
                    if (addr_cnt == {ADDR_W{1'b1}}) begin
                        addr_cnt <= '0;
                        state    <= S_DRAIN;
                    end else begin
                        addr_cnt <= addr_cnt + 1'b1;
                        mem_addr <= addr_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
`ifdef RAM_BIST_INV_PASS_EN
                    if (!inv_pass) begin
                        inv_pass <= 1'b1;
                        addr_cnt <= '0;
                        mem_we   <= 1'b1;
                        mem_addr <= '0;
                        mem_din  <= expected_data(1'b1, '0);
                        state    <= S_WRITE;
                    end else begin
                        done  <= 1'b1;
                        pass  <= (err_next == 8'd0);
                        state <= S_DONE;
                    end
`else
                    done  <= 1'b1;
                    pass  <= (err_next == 8'd0);
                    state <= S_DONE;
`endif
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: directed self-checking bench for ram_bist with a fault-injecting RAM model.
// Honours RAM_BIST_INV_PASS_EN to select single- or dual-pass expectations.
module tb_ram_bist;

`ifdef RAM_BIST_INV_PASS_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif
    localparam int DONE_EDGES = INV ? 514 : 257;
    localparam int WRITES     = INV ? 256 : 128;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [6:0] fail_addr;
    logic [7:0] fail_data;
    logic       mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    logic [7:0] mem   [128];
    logic [7:0] flip  [128];
    logic [7:0] stuck [128];

    int checks;
    int failures;
    int we_cnt;
    int done_cnt;

    ram_bist dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read with per-address bit-flip and stuck-at-1 faults.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        else        mem_dout <= (mem[mem_addr] ^ flip[mem_addr]) | stuck[mem_addr];
    end

    // Activity monitor for write cycles and done pulses.
    always @(negedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (done)   done_cnt <= done_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearFaults();
        for (int i = 0; i < 128; i++) begin
            flip[i]  = 8'h00;
            stuck[i] = 8'h00;
        end
    endtask

    // Pulse start, optionally re-pulse it mid-run or pull reset, and wait for done.
    task automatic applyStimulus(input int restart_at, input int reset_at,
                                 output int lat, output int writes, output int dones);
        int edges;
        bit got;
        int we_base;
        int done_base;
        we_base   = we_cnt;
        done_base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0;
        got   = 1'b0;
        lat   = -1;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (edges == 0) begin
                checkOutput("first_busy", busy, 1);
                checkOutput("first_we", mem_we, 1);
                checkOutput("first_addr", mem_addr, 0);
                checkOutput("first_din", mem_din, 8'hAA);
            end
            if (edges == 257) checkOutput("cyc258_din", mem_din, INV ? 8'h55 : 8'h00);
            start = (edges == restart_at);
            if (edges == reset_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput("midrst_we", mem_we, 0);
                checkOutput("midrst_busy", busy, 0);
                checkOutput("midrst_addr", mem_addr, 0);
                checkOutput("midrst_din", mem_din, 0);
                checkOutput("midrst_pass", pass, 0);
                @(negedge clk);
                rst_n = 1'b1;
                got = 1'b1;
                lat = edges;
            end else if (done) begin
                got = 1'b1;
                lat = edges;
            end else begin
                @(posedge clk);
                edges++;
            end
        end
        start = 1'b0;
        if (!got) checkOutput("run_timeout", 0, 1);
        #2;
        writes = we_cnt - we_base;
        dones  = done_cnt - done_base;
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        if (!ok) checkOutput("wait_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        int wr;
        int dn;
        int base;
        bit ok;
        checks   = 0;
        failures = 0;
        we_cnt   = 0;
        done_cnt = 0;
        start    = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        clearFaults();

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_err", err_count, 0);
        checkOutput("rst_faddr", fail_addr, 0);
        checkOutput("rst_fdata", fail_data, 0);
        checkOutput("rst_we", mem_we, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_din", mem_din, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fault-free run
        applyStimulus(-1, -1, lat, wr, dn);
        checkOutput("ok_latency", lat, DONE_EDGES);
        checkOutput("ok_writes", wr, WRITES);
        checkOutput("ok_dones", dn, 1);
        checkOutput("ok_pass", pass, 1);
        checkOutput("ok_err", err_count, 0);

        // Single-bit read fault at address 10
        clearFaults();
        flip[10] = 8'h01;
        applyStimulus(-1, -1, lat, wr, dn);
        checkOutput("f10_pass", pass, 0);
        checkOutput("f10_err", err_count, INV ? 2 : 1);
        checkOutput("f10_faddr", fail_addr, 10);
        checkOutput("f10_fdata", fail_data, 8'hA1);

        // Faults at addresses 5 and 9
        clearFaults();
        flip[5] = 8'h01;
        flip[9] = 8'h01;
        applyStimulus(-1, -1, lat, wr, dn);
        checkOutput("f59_pass", pass, 0);
        checkOutput("f59_err", err_count, INV ? 4 : 2);
        checkOutput("f59_faddr", fail_addr, 5);
        checkOutput("f59_fdata", fail_data, 8'hAE);

        // Bit7 stuck-at-1 at address 20: only visible with the inverted pattern
        clearFaults();
        stuck[20] = 8'h80;
        applyStimulus(-1, -1, lat, wr, dn);
        checkOutput("s20_pass", pass, INV ? 0 : 1);
        checkOutput("s20_err", err_count, INV ? 1 : 0);
        checkOutput("s20_faddr", fail_addr, INV ? 20 : 0);
        checkOutput("s20_fdata", fail_data, INV ? 8'hC1 : 8'h00);

        // Every address faulty: dual-pass run saturates the error counter
        clearFaults();
        for (int i = 0; i < 128; i++) flip[i] = 8'h01;
        applyStimulus(-1, -1, lat, wr, dn);
        checkOutput("all_err", err_count, INV ? 255 : 128);
        checkOutput("all_faddr", fail_addr, 0);
        checkOutput("all_fdata", fail_data, 8'hAB);

        // start re-asserted while busy is ignored
        clearFaults();
        applyStimulus(49, -1, lat, wr, dn);
        checkOutput("rb_latency", lat, DONE_EDGES);
        checkOutput("rb_dones", dn, 1);
        checkOutput("rb_writes", wr, WRITES);
        base = we_cnt;
        repeat (5) @(negedge clk);
        #2;
        checkOutput("rb_idle_busy", busy, 0);
        checkOutput("rb_no_rewrite", we_cnt - base, 0);
        checkOutput("rb_pass_held", pass, 1);

        // Reset in the middle of WRITE, then a complete run
        applyStimulus(-1, 39, lat, wr, dn);
        checkOutput("mr_dones", dn, 0);
        applyStimulus(-1, -1, lat, wr, dn);
        checkOutput("mr_rerun_pass", pass, 1);
        checkOutput("mr_rerun_err", err_count, 0);

        // start held through DONE restarts after one IDLE cycle
        @(negedge clk);
        start = 1'b1;
        waitDone(ok);
        @(negedge clk);
        checkOutput("hold_idle_busy", busy, 0);
        @(negedge clk);
        checkOutput("hold_restart_busy", busy, 1);
        checkOutput("hold_restart_we", mem_we, 1);
        start = 1'b0;
        waitDone(ok);
        checkOutput("hold_pass", pass, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
